// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline's ID/EX control and the hazard controller:
// decode inputs, redirect/clear controls, and the stall/flush/forward/counter outputs.
interface hazard_ctrl_if;
  logic [31:0] i_id_instr;
  logic        i_id_vld;
  logic        i_id_rd_wren;
  logic        i_id_mem_rden;
  logic        i_ex_br_taken;
  logic        i_cnt_clr;
  logic        o_stall;
  logic        o_flush;
  logic [1:0]  o_fwd_a_sel;
  logic [1:0]  o_fwd_b_sel;
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;

  modport master (
    output i_id_instr, i_id_vld, i_id_rd_wren, i_id_mem_rden, i_ex_br_taken, i_cnt_clr,
    input  o_stall, o_flush, o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_instr, i_id_vld, i_id_rd_wren, i_id_mem_rden, i_ex_br_taken, i_cnt_clr,
    output o_stall, o_flush, o_fwd_a_sel, o_fwd_b_sel, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: tracks EX/MEM/WB in shadow registers to
// produce load-use stalls, branch flushes, operand forwarding selects and event counters.
module hazard_ctrl (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       wren;
    logic       ld;
  } stage_t;

  typedef struct packed {
    stage_t     base;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } ex_stage_t;

  ex_stage_t   ex_q;
  ex_stage_t   ex_d;
  stage_t      mem_q;
  stage_t      wb_q;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic        load_use;
  logic        stall;
  logic        flush;
  logic        unused_bits;

  assign id_rs1      = bus.i_id_instr[19:15];
  assign id_rs2      = bus.i_id_instr[24:20];
  assign id_rd       = bus.i_id_instr[11:7];
  assign unused_bits = ^{bus.i_id_instr[31:25], bus.i_id_instr[14:12], wb_q.ld};

  always_comb begin
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    case (bus.i_id_instr[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: id_rs1_used = 1'b1;
      default: ;
    endcase
  end

  // A load sitting in EX cannot forward yet, so a dependent ID instruction must wait one cycle.
  always_comb begin
    load_use = ex_q.base.vld & ex_q.base.ld & ex_q.base.wren & (ex_q.base.rd != 5'd0) &
               bus.i_id_vld &
               ((id_rs1_used & (id_rs1 == ex_q.base.rd)) |
                (id_rs2_used & (id_rs2 == ex_q.base.rd)));
  end

  assign flush       = bus.i_ex_br_taken;
  assign stall       = load_use & ~bus.i_ex_br_taken;
  assign bus.o_flush = flush;
  assign bus.o_stall = stall;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input stage_t mem, input stage_t wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (used) begin
      if (mem.vld & mem.wren & (mem.rd != 5'd0) & (mem.rd == rs))
        sel = 2'd1;
      else if (wb.vld & wb.wren & (wb.rd != 5'd0) & (wb.rd == rs))
        sel = 2'd2;
    end
    return sel;
  endfunction

  assign bus.o_fwd_a_sel = fwd_sel(ex_q.rs1_used & ex_q.base.vld, ex_q.rs1, mem_q, wb_q);
  assign bus.o_fwd_b_sel = fwd_sel(ex_q.rs2_used & ex_q.base.vld, ex_q.rs2, mem_q, wb_q);

  always_comb begin
    ex_d = '0;
    if (bus.i_id_vld & ~stall & ~flush) begin
      ex_d.base.vld  = 1'b1;
      ex_d.base.rd   = id_rd;
      ex_d.base.wren = bus.i_id_rd_wren;
      ex_d.base.ld   = bus.i_id_mem_rden;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rs1_used  = id_rs1_used;
      ex_d.rs2_used  = id_rs2_used;
    end
  end

  // MEM and WB always advance; only EX can take a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.base;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (bus.i_cnt_clr)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      flush_cnt <= '0;
    else if (bus.i_cnt_clr)
      flush_cnt <= '0;
    else if (flush && flush_cnt != 16'hFFFF)
      flush_cnt <= flush_cnt + 16'd1;
  end

  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations
// per cycle and an independent monitor compares them against the outputs at the falling edge.
module tb_hazard_ctrl;
  localparam int X = -1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int stall;
    int flush;
    int fa;
    int fb;
    int sc;
    int fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic applyStimulus(input string name, input logic rst, input logic [31:0] instr,
                               input logic vld, input logic wren, input logic ld,
                               input logic br, input logic clr,
                               input int es, input int ef, input int efa, input int efb,
                               input int esc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n             = rst;
    bus.i_id_instr    = instr;
    bus.i_id_vld      = vld;
    bus.i_id_rd_wren  = wren;
    bus.i_id_mem_rden = ld;
    bus.i_ex_br_taken = br;
    bus.i_cnt_clr     = clr;
    e.stall = es;
    e.flush = ef;
    e.fa    = efa;
    e.fb    = efb;
    e.sc    = esc;
    e.fc    = efc;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic ins(input string name, input logic [31:0] instr, input logic ld,
                     input int es, input int efa, input int efb, input int esc);
    applyStimulus(name, 1'b1, instr, 1'b1, 1'b1, ld, 1'b0, 1'b0, es, 0, efa, efb, esc, X);
  endtask

  task automatic nop(input string name, input int efa, input int efb, input int esc);
    applyStimulus(name, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, efa, efb, esc, X);
  endtask

  task automatic checkField(input string name, input string field, input int act, input int exp);
    if (exp != X) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("[TB] FAIL %s.%s got %0h expected %0h", name, field, act, exp);
      end
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checkField(name, "stall", int'(bus.o_stall), e.stall);
    checkField(name, "flush", int'(bus.o_flush), e.flush);
    checkField(name, "fwd_a", int'(bus.o_fwd_a_sel), e.fa);
    checkField(name, "fwd_b", int'(bus.o_fwd_b_sel), e.fb);
    checkField(name, "stall_cnt", int'(bus.o_stall_cnt), e.sc);
    checkField(name, "flush_cnt", int'(bus.o_flush_cnt), e.fc);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) checkOutput(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] add5, sub6, addi10, or9, addi12a, addi12b, add13;
    logic [31:0] lw7, add8, addi0, add4, lw0, add14;
    add5    = r_type(5'd5, 5'd1, 5'd2, 3'b000);
    sub6    = r_type(5'd6, 5'd5, 5'd3, 3'b000);
    addi10  = addi(5'd10, 5'd11, 12'd1);
    or9     = r_type(5'd9, 5'd3, 5'd5, 3'b110);
    addi12a = addi(5'd12, 5'd0, 12'd1);
    addi12b = addi(5'd12, 5'd0, 12'd2);
    add13   = r_type(5'd13, 5'd12, 5'd12, 3'b000);
    lw7     = 32'h0000A383;
    add8    = 32'h00738433;
    addi0   = addi(5'd0, 5'd1, 12'd5);
    add4    = r_type(5'd4, 5'd0, 5'd0, 3'b000);
    lw0     = lw(5'd0, 5'd2);
    add14   = r_type(5'd14, 5'd0, 5'd0, 3'b000);

    rst_n             = 1'b0;
    bus.i_id_instr    = '0;
    bus.i_id_vld      = 1'b0;
    bus.i_id_rd_wren  = 1'b0;
    bus.i_id_mem_rden = 1'b0;
    bus.i_ex_br_taken = 1'b0;
    bus.i_cnt_clr     = 1'b0;
    $display("[TB] start");

    applyStimulus("rst_idle", 1'b0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst_flush", 1'b0, 32'd0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);

    ins("mem_first", add5, 1'b0, 0, 0, 0, 0);
    ins("mem_ex_add", sub6, 1'b0, 0, 0, 0, 0);
    nop("mem_fwd", 1, 0, 0);
    nop("mem_drain", 0, 0, 0);

    ins("wb_add", add5, 1'b0, 0, 0, 0, 0);
    ins("wb_addi", addi10, 1'b0, 0, 0, 0, 0);
    ins("wb_or", or9, 1'b0, 0, 0, 0, 0);
    nop("wb_fwd", 0, 2, 0);

    ins("pri_a", addi12a, 1'b0, 0, 0, 0, 0);
    ins("pri_b", addi12b, 1'b0, 0, 0, 0, 0);
    ins("pri_use", add13, 1'b0, 0, 0, 0, 0);
    nop("pri_fwd", 1, 1, 0);

    ins("lu_load", lw7, 1'b1, 0, 0, 0, 0);
    ins("lu_stall", add8, 1'b0, 1, 0, 0, 0);
    ins("lu_hold", add8, 1'b0, 0, 0, 0, 1);
    nop("lu_fwd", 2, 2, 1);

    ins("x0_addi", addi0, 1'b0, 0, 0, 0, 1);
    ins("x0_add", add4, 1'b0, 0, 0, 0, 1);
    ins("x0_lw", lw0, 1'b1, 0, 0, 0, 1);
    ins("x0_use", add14, 1'b0, 0, 0, 0, 1);
    nop("x0_drain", 0, 0, 1);

    applyStimulus("both_load", 1'b1, lw7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("both_evt", 1'b1, add8, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    applyStimulus("both_after", 1'b1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Jump the stall counter close to its limit instead of running ~65k stall pairs.
    @(posedge clk);
    #1;
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;

    ins("sat_load", lw7, 1'b1, 0, 0, 0, 'hFFFE);
    ins("sat_stall1", add8, 1'b0, 1, 0, 0, 'hFFFE);
    ins("sat_load2", lw7, 1'b1, 0, 0, 0, 'hFFFF);
    ins("sat_stall2", add8, 1'b0, 1, 0, 0, 'hFFFF);
    ins("sat_hold", lw7, 1'b1, 0, 0, 0, 'hFFFF);
    applyStimulus("clr_stall", 1'b1, add8, 1, 1, 0, 0, 1, 1, 0, 0, 0, 'hFFFF, 1);
    applyStimulus("clr_after", 1'b1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("rst_prep_flush", 1'b1, 32'd0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus("rst_prep_load", 1'b1, lw7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("rst_mid_stall", 1'b0, add8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst_first", 1'b1, add8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst_drain", 1'b1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_id_instr  in  32  instruction in ID stage
- i_id_vld  in  1  ID instruction valid (ctrl_unit o_insn_vld)
- i_id_rd_wren  in  1  ID writes rd (ctrl_unit o_rd_wren)
- i_id_mem_rden  in  1  ID is a load (ctrl_unit o_mem_rden)
- i_ex_br_taken  in  1  EX-stage redirect resolved this cycle
- i_cnt_clr  in  1  synchronous clear of both counters
- o_stall  out  1  hold PC and IF/ID, bubble into EX
- o_flush  out  1  squash IF/ID and ID/EX contents
- o_fwd_a_sel  out  2  EX rs1 operand source
- o_fwd_b_sel  out  2  EX rs2 operand source
- o_stall_cnt  out  16  load-use stall cycles
- o_flush_cnt  out  16  flush cycles

Function
REQ-003 The block SHALL model a 5-stage pipeline (IF, ID, EX, MEM, WB) using shadow registers for EX, MEM and WB.
REQ-004 Each shadow register SHALL hold {vld, rd[4:0], wren, ld}; the EX shadow SHALL also hold rs1[4:0], rs2[4:0], rs1_used and rs2_used.
REQ-005 The block SHALL decode source usage from i_id_instr[6:0]:
- 0110011, 0100011, 1100011: rs1 and rs2
- 0010011, 0000011, 1100111: rs1 only
- all other opcodes: none
REQ-006 Source fields SHALL be rs1=[19:15], rs2=[24:20] and rd=[11:7].
REQ-007 load_use SHALL be 1 when all of the following hold: EX.vld & EX.ld & EX.wren & EX.rd!=0 & i_id_vld, and (rs1_used & rs1==EX.rd, or rs2_used & rs2==EX.rd).
REQ-008 o_flush SHALL equal i_ex_br_taken, combinationally.
REQ-009 o_stall SHALL equal load_use & ~i_ex_br_taken, so a flush wins over a stall when both occur.
REQ-010 Every clock edge SHALL update the shadows as follows:
- WB<=MEM and MEM<=EX unconditionally; MEM and WB never stall.
- EX<=bubble (vld=0) if o_flush, o_stall or ~i_id_vld.
- Otherwise EX<=ID fields {1, rd, i_id_rd_wren, i_id_mem_rden, rs1, rs2, used flags}.
REQ-011 A stall SHALL last exactly one cycle per load-use pair, because the load has advanced to MEM by the next cycle.
REQ-012 o_fwd_a_sel SHALL be chosen in priority order for EX.rs1_used & EX.vld:
- 2'd1 if MEM.vld & MEM.wren & MEM.rd!=0 & MEM.rd==EX.rs1
- else 2'd2 if the same condition holds on WB
- else 2'd0
REQ-013 o_fwd_b_sel SHALL follow the same rule using rs2; the value 2'd3 SHALL never be driven.
REQ-014 Register x0 SHALL never cause forwarding or a stall.
REQ-015 Forwarding outputs SHALL be combinational from the shadow registers, with no added latency.
REQ-016 o_stall_cnt SHALL increment on each clock edge where o_stall=1, and o_flush_cnt on each edge where o_flush=1.
REQ-017 Both counters SHALL saturate at 16'hFFFF.
REQ-018 i_cnt_clr SHALL zero both counters at the next edge and SHALL take priority over increment.

Reset
REQ-019 While i_rst_n=0, all shadow vld bits SHALL be 0 and both counters SHALL be 0, taking effect immediately without waiting for a clock.
REQ-020 During reset, o_stall, o_fwd_a_sel and o_fwd_b_sel SHALL be 0, and o_flush SHALL follow i_ex_br_taken.
REQ-021 Reset asserted mid-stall SHALL drop o_stall in the same cycle; after reset deassertion, the first instruction SHALL see no hazards.

Verification
REQ-022 The bench SHALL cover forwarding from MEM: add x5,x1,x2 then sub x6,x5,x3 back-to-back -> with sub in EX, o_fwd_a_sel=1, o_fwd_b_sel=0, o_stall=0.
REQ-023 The bench SHALL cover forwarding from WB: add x5,x1,x2; unrelated addi; then or x9,x3,x5 -> with or in EX, o_fwd_b_sel=2, o_fwd_a_sel=0.
REQ-024 The bench SHALL cover load-use: 0x0000A383 (lw x7,0(x1)) then 0x00738433 (add x8,x7,x7) -> o_stall=1 for exactly one cycle, then o_fwd_a_sel=o_fwd_b_sel=2, o_stall_cnt=1.
REQ-025 The bench SHALL cover x0: addi x0,x1,5 then add x4,x0,x0, and lw x0 then a use of x0 -> o_stall=0 and fwd selects 0 throughout.
REQ-026 The bench SHALL cover simultaneous events: a load-use condition with i_ex_br_taken=1 in the same cycle -> o_flush=1, o_stall=0, o_flush_cnt+1, o_stall_cnt unchanged; the next EX shadow is a bubble.
REQ-027 The bench SHALL cover counter limits: preload 16'hFFFF stall cycles then another stall -> o_stall_cnt stays 16'hFFFF; i_cnt_clr=1 together with a stall -> counter reads 0 next cycle.
